// File: rtl/sdrd_slide_seq.sv
// SD-card slideshow sequencer: request image N, count streamed RGB words, hold, advance.
// All outputs registered (one cycle from sampled input); REQ held until REQ_ACK, RGB_WR accepted every cycle.
module sdrd_slide_seq #(
  parameter int unsigned NUM_IMG     = 8,
  parameter int unsigned IDX_W       = 8,
  parameter int unsigned IMG_WORDS   = 115200,
  parameter int unsigned HOLD_CYC    = 50000000,
  parameter int unsigned TIMEOUT_CYC = 100000000
) (
  input  logic             CLK,
  input  logic             RST_X,
  input  logic             SD_INIT,
  input  logic             ENABLE,
  input  logic             SKIP,
  output logic             REQ,
  output logic [IDX_W-1:0] REQ_IDX,
  input  logic             REQ_ACK,
  input  logic             RGB_WR,
  output logic [23:0]      WORD_CNT,
  output logic             FRAME_DONE,
  output logic             LOAD_ERR,
  output logic [2:0]       STATE
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_LOAD = 3'd2,
    ST_HOLD = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  localparam logic [23:0]      IMG_LAST  = 24'(IMG_WORDS - 1);
  localparam logic [31:0]      HOLD_LAST = 32'(HOLD_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_IMG - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  // Watchdog holds (cycles since last strobe - 1); deciding one cycle early
  // makes STATE show ERR exactly TIMEOUT_CYC cycles after the last strobe.
  localparam logic [31:0]      WD_LAST   = 32'((TIMEOUT_CYC > 2) ? (TIMEOUT_CYC - 2) : 0);

  state_e           state_q, state_d;
  logic             req_q, req_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_next;
  logic [23:0]      cnt_q, cnt_d;
  logic             fd_q, fd_d;
  logic             err_q, err_d;
  logic [31:0]      wdog_q, wdog_d;
  logic [31:0]      hold_q, hold_d;

  assign idx_next = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_ONE;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    fd_d    = 1'b0;
    err_d   = err_q;
    wdog_d  = wdog_q;
    hold_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (ENABLE) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (REQ_ACK) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
          wdog_d  = '0;
        end
      end
      ST_LOAD: begin
        // A strobe always beats an expiring watchdog.
        if (RGB_WR) begin
          cnt_d  = cnt_q + 24'd1;
          wdog_d = '0;
          if (cnt_q == IMG_LAST) begin
            fd_d    = 1'b1;
            err_d   = 1'b0;
            idx_d   = idx_next;
            state_d = ST_HOLD;
          end
        end else if (wdog_q >= WD_LAST) begin
          state_d = ST_ERR;
        end else begin
          wdog_d = wdog_q + 32'd1;
        end
      end
      ST_HOLD: begin
        if (SKIP || (hold_q == HOLD_LAST)) begin
          state_d = ENABLE ? ST_REQ : ST_IDLE;
        end else begin
          hold_d = hold_q + 32'd1;
        end
      end
      ST_ERR: begin
        err_d   = 1'b1;
        idx_d   = idx_next;
        state_d = ENABLE ? ST_REQ : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Losing the card restarts the show from image 0; LOAD_ERR is left alone.
    if (!SD_INIT) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
      fd_d    = 1'b0;
      wdog_d  = '0;
      hold_d  = '0;
    end
    req_d = (state_d == ST_REQ);
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      fd_q    <= 1'b0;
      err_q   <= 1'b0;
      wdog_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      fd_q    <= fd_d;
      err_q   <= err_d;
      wdog_q  <= wdog_d;
      hold_q  <= hold_d;
    end
  end

  assign STATE      = state_q;
  assign REQ        = req_q;
  assign REQ_IDX    = idx_q;
  assign WORD_CNT   = cnt_q;
  assign FRAME_DONE = fd_q;
  assign LOAD_ERR   = err_q;

endmodule

// File: tb/tb_sdrd_slide_seq.sv
// Directed bench for sdrd_slide_seq with NUM_IMG=3, IMG_WORDS=4, HOLD_CYC=5, TIMEOUT_CYC=8.
module tb_sdrd_slide_seq;

  logic        CLK = 1'b0;
  logic        RST_X = 1'b0;
  logic        SD_INIT = 1'b0;
  logic        ENABLE = 1'b0;
  logic        SKIP = 1'b0;
  logic        REQ_ACK = 1'b0;
  logic        RGB_WR = 1'b0;
  logic        REQ;
  logic [7:0]  REQ_IDX;
  logic [23:0] WORD_CNT;
  logic        FRAME_DONE;
  logic        LOAD_ERR;
  logic [2:0]  STATE;

  int n_chk  = 0;
  int n_pass = 0;
  int fd_cnt = 0;

  sdrd_slide_seq #(
    .NUM_IMG(3), .IDX_W(8), .IMG_WORDS(4), .HOLD_CYC(5), .TIMEOUT_CYC(8)
  ) dut (
    .CLK(CLK), .RST_X(RST_X), .SD_INIT(SD_INIT), .ENABLE(ENABLE), .SKIP(SKIP),
    .REQ(REQ), .REQ_IDX(REQ_IDX), .REQ_ACK(REQ_ACK), .RGB_WR(RGB_WR),
    .WORD_CNT(WORD_CNT), .FRAME_DONE(FRAME_DONE), .LOAD_ERR(LOAD_ERR), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (RST_X && FRAME_DONE) fd_cnt <= fd_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    else n_pass++;
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // From a REQ cycle through the first HOLD cycle of a nominal 4-word frame.
  task automatic load_frame(input int idx, input int ack_dly, input bit dis);
    chk("req_hi", 32'(REQ), 1);
    chk("req_idx", 32'(REQ_IDX), idx);
    for (int i = 0; i < ack_dly; i++) begin
      cyc();
      chk("req_wait", 32'(REQ), 1);
    end
    REQ_ACK = 1'b1;
    cyc();
    REQ_ACK = 1'b0;
    chk("load_st", 32'(STATE), 2);
    chk("req_lo", 32'(REQ), 0);
    chk("cnt_clr", 32'(WORD_CNT), 0);
    if (dis) ENABLE = 1'b0;
    RGB_WR = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk("cnt_run", 32'(WORD_CNT), i);
      chk("fd_early", 32'(FRAME_DONE), 0);
    end
    cyc();
    RGB_WR = 1'b0;
    chk("fd_pulse", 32'(FRAME_DONE), 1);
    chk("cnt_final", 32'(WORD_CNT), 4);
    chk("hold_st", 32'(STATE), 3);
    chk("idx_adv", 32'(REQ_IDX), (idx + 1) % 3);
  endtask

  // Remaining HOLD cycles after HOLD cycle 0, then step out of HOLD.
  task automatic hold_cycles(input int n);
    for (int i = 1; i < n; i++) begin
      cyc();
      chk("hold_len", 32'(STATE), 3);
      chk("fd_once", 32'(FRAME_DONE), 0);
    end
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) cyc();
    chk("rst_state", 32'(STATE), 0);
    chk("rst_req", 32'(REQ), 0);
    chk("rst_idx", 32'(REQ_IDX), 0);
    chk("rst_cnt", 32'(WORD_CNT), 0);
    chk("rst_fd", 32'(FRAME_DONE), 0);
    chk("rst_err", 32'(LOAD_ERR), 0);
    RST_X = 1'b1;
    cyc();
    chk("idle_wait", 32'(STATE), 0);

    // Nominal frame and wrap over three images
    SD_INIT = 1'b1;
    ENABLE  = 1'b1;
    cyc();
    chk("first_req", 32'(STATE), 1);
    load_frame(0, 2, 1'b0);
    hold_cycles(5);
    chk("after_hold", 32'(STATE), 1);
    load_frame(1, 0, 1'b0);
    hold_cycles(5);
    load_frame(2, 1, 1'b0);
    hold_cycles(5);
    chk("wrap_idx", 32'(REQ_IDX), 0);
    chk("fd_count", 32'(fd_cnt), 3);

    // Timeout: two words then silence
    REQ_ACK = 1'b1;
    cyc();
    REQ_ACK = 1'b0;
    RGB_WR = 1'b1;
    cyc();
    cyc();
    RGB_WR = 1'b0;
    chk("to_cnt", 32'(WORD_CNT), 2);
    for (int i = 2; i <= 7; i++) begin
      cyc();
      chk("to_wait", 32'(STATE), 2);
    end
    cyc();
    chk("to_err_st", 32'(STATE), 4);
    chk("to_err_flag0", 32'(LOAD_ERR), 0);
    cyc();
    chk("to_req", 32'(STATE), 1);
    chk("to_err_flag", 32'(LOAD_ERR), 1);
    chk("to_idx", 32'(REQ_IDX), 1);
    load_frame(1, 0, 1'b0);
    chk("err_clear", 32'(LOAD_ERR), 0);
    hold_cycles(5);

    // SD_INIT drop mid-LOAD at index 2
    REQ_ACK = 1'b1;
    cyc();
    REQ_ACK = 1'b0;
    RGB_WR = 1'b1;
    cyc();
    cyc();
    RGB_WR  = 1'b0;
    SD_INIT = 1'b0;
    cyc();
    chk("drop_st", 32'(STATE), 0);
    chk("drop_cnt", 32'(WORD_CNT), 0);
    chk("drop_idx", 32'(REQ_IDX), 0);
    chk("drop_req", 32'(REQ), 0);
    SD_INIT = 1'b1;
    cyc();
    chk("reinit_st", 32'(STATE), 1);
    chk("reinit_idx", 32'(REQ_IDX), 0);

    // SKIP in HOLD cycle 1
    load_frame(0, 0, 1'b0);
    cyc();
    chk("skip_hold", 32'(STATE), 3);
    SKIP = 1'b1;
    cyc();
    SKIP = 1'b0;
    chk("skip_req", 32'(STATE), 1);
    chk("skip_idx", 32'(REQ_IDX), 1);

    // ENABLE low during LOAD: frame completes, then IDLE
    load_frame(1, 0, 1'b1);
    hold_cycles(5);
    chk("dis_idle", 32'(STATE), 0);
    chk("dis_req", 32'(REQ), 0);
    ENABLE = 1'b1;
    cyc();
    chk("reen_st", 32'(STATE), 1);
    chk("reen_idx", 32'(REQ_IDX), 2);

    // Strobe exactly at watchdog expiry, then surplus words in HOLD
    REQ_ACK = 1'b1;
    cyc();
    REQ_ACK = 1'b0;
    RGB_WR = 1'b1;
    cyc();
    RGB_WR = 1'b0;
    repeat (6) cyc();
    RGB_WR = 1'b1;
    cyc();
    chk("wd_edge_st", 32'(STATE), 2);
    chk("wd_edge_cnt", 32'(WORD_CNT), 2);
    cyc();
    cyc();
    chk("wd_edge_fd", 32'(FRAME_DONE), 1);
    chk("wd_edge_idx", 32'(REQ_IDX), 0);
    cyc();
    cyc();
    RGB_WR = 1'b0;
    chk("surplus_cnt", 32'(WORD_CNT), 4);
    chk("surplus_st", 32'(STATE), 3);

    // Asynchronous reset mid-HOLD
    #3;
    RST_X = 1'b0;
    #1;
    chk("arst_state", 32'(STATE), 0);
    chk("arst_cnt", 32'(WORD_CNT), 0);
    chk("arst_req", 32'(REQ), 0);
    chk("arst_fd", 32'(FRAME_DONE), 0);
    chk("arst_err", 32'(LOAD_ERR), 0);
    chk("arst_idx", 32'(REQ_IDX), 0);
    cyc();
    RST_X = 1'b1;
    cyc();
    chk("post_rst_req", 32'(STATE), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
